// File: rtl/zreset_seq_pkg.sv
// Shared types and constants for the Z80 reset sequencer.
// Imported by the sequencer top.
package zreset_seq_pkg;

  typedef enum logic [1:0] {
    ST_POR    = 2'd0,
    ST_ASSERT = 2'd1,
    ST_HOLD   = 2'd2,
    ST_IDLE   = 2'd3
  } state_e;

  localparam logic SRC_SPI = 1'b0;
  localparam logic SRC_BTN = 1'b1;

  localparam logic [1:0] ROM_DEFAULT = 2'b00;

endpackage

// File: rtl/zreset_seq_btn_debounce.sv
// Front-panel button synchroniser and debouncer.
// Emits a one-cycle pulse when the debounced level falls.
module btn_debounce #(
  parameter int DEB_BITS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic level_o,
  output logic fall_o
);

  logic                s1_q, s2_q, prev_q;
  logic                lvl_q, lvl_d;
  logic                fall_q;
  logic [DEB_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    if (s2_q != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      lvl_d = s2_q;
    end
  end

  // Released (high) is the idle level, so the chain resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
      lvl_q  <= 1'b1;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= btn_n_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      lvl_q  <= lvl_d;
      fall_q <= lvl_q & ~lvl_d;
      cnt_q  <= cnt_d;
    end
  end

  assign level_o = lvl_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/zreset_seq.sv
// Timed Z80 reset sequencer with ROM-page latch.
// Merges SPI reset requests and a debounced front-panel button.
module zreset_seq
  import zreset_seq_pkg::*;
#(
  parameter int         RST_CYCLES = 4096,
  parameter int         DEB_BITS   = 16,
  parameter logic [1:0] BTN_ROM    = ROM_DEFAULT
) (
  input  logic       fclk,
  input  logic       rst_n,
  input  logic       genrst,
  input  logic [1:0] rstrom,
  input  logic       btn_rst_n,
  output logic       zrst_n,
  output logic [1:0] rom_sel,
  output logic       rst_busy,
  output logic       rst_src
);

  localparam int CW = $clog2(RST_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(RST_CYCLES - 1);

  logic          g_s1_q, g_s2_q, g_s3_q;
  logic          spi_ev_q;
  logic [1:0]    rom_s1_q, rom_s2_q;
  logic          btn_lvl, btn_fall;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          src_q, src_d;
  logic [1:0]    rom_q, rom_d;
  logic          zrst_q, busy_q;

  btn_debounce #(
    .DEB_BITS(DEB_BITS)
  ) u_deb (
    .clk    (fclk),
    .rst_n  (rst_n),
    .btn_n_i(btn_rst_n),
    .level_o(btn_lvl),
    .fall_o (btn_fall)
  );

  // Edge is registered once more so both event paths are flopped.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      g_s1_q   <= 1'b0;
      g_s2_q   <= 1'b0;
      g_s3_q   <= 1'b0;
      spi_ev_q <= 1'b0;
      rom_s1_q <= 2'b00;
      rom_s2_q <= 2'b00;
    end else begin
      g_s1_q   <= genrst;
      g_s2_q   <= g_s1_q;
      g_s3_q   <= g_s2_q;
      spi_ev_q <= g_s2_q & ~g_s3_q;
      rom_s1_q <= rstrom;
      rom_s2_q <= rom_s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    rom_d   = rom_q;
    unique case (state_q)
      ST_POR: begin
        if (cnt_q == LAST) state_d = ST_HOLD;
      end
      ST_ASSERT: begin
        if (cnt_q == LAST) begin
          state_d = ST_HOLD;
          rom_d   = (src_q == SRC_SPI) ? rom_s2_q : BTN_ROM;
        end
      end
      ST_HOLD: begin
        if (!g_s2_q && btn_lvl) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (spi_ev_q) begin
          state_d = ST_ASSERT;
          src_d   = SRC_SPI;
        end else if (btn_fall) begin
          state_d = ST_ASSERT;
          src_d   = SRC_BTN;
        end
      end
      default: state_d = ST_POR;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_POR;
      cnt_q   <= '0;
      src_q   <= SRC_SPI;
      rom_q   <= 2'b00;
      zrst_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      rom_q   <= rom_d;
      zrst_q  <= (state_d == ST_IDLE);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign zrst_n   = zrst_q;
  assign rom_sel  = rom_q;
  assign rst_busy = busy_q;
  assign rst_src  = src_q;

endmodule

// File: doc/zreset_seq.md
Name: zreset_seq

Overview:
- Consumes the CPU-reset request (`genrst`) and ROM-select code (`rstrom`) from the SPI slave stage, which runs in the SPI clock domain.
- Also takes a raw front-panel reset button.
- Produces a timed, glitch-free Z80 reset and a ROM-page selection latched at reset release, both in the `fclk` domain.
- Sits between the SPI slave and the CPU/memory-mapping logic.

Parameters:
- RST_CYCLES, 4096: `fclk` cycles `zrst_n` is held low per reset event (≥2).
- DEB_BITS, 16: width of the button debounce counter; the button must be stable for 2^DEB_BITS cycles.
- BTN_ROM, 2'b00: ROM code loaded on a button-initiated reset.

Ports:
- fclk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- genrst  in  1  reset request from SPI stage (async to fclk), level
- rstrom  in  2  ROM code from SPI stage (async to fclk)
- btn_rst_n  in  1  raw reset button, active low, bouncing
- zrst_n  out  1  Z80 reset, active low, registered
- rom_sel  out  2  ROM page for the memory mapper, registered
- rst_busy  out  1  high while a reset sequence is in progress
- rst_src  out  1  source of the last reset: 0 = SPI, 1 = button

Behaviour:
- **Clock and reset:** one clock `fclk`. Reset is asynchronous and active-low on `rst_n`; all flops clear on `rst_n` low.
- **Values while `rst_n` = 0:**
  - `zrst_n` = 0, `rom_sel` = 2'b00, `rst_busy` = 1, `rst_src` = 0.
  - FSM = POR, counter = 0, debounce state = released.
- **Synchronisers:** `genrst`, `rstrom[1:0]` and `btn_rst_n` each pass through 2 flops before any use.
- **SPI request event:** rising edge of the synchronised `genrst`, detected by a third flop. It takes effect one cycle after the edge is seen.
- **Debouncer:**
  - Counter reloads on any change of the synchronised button. When the counter saturates at 2^DEB_BITS-1, the debounced level takes the synchronised value.
  - Button event = debounced level going 1→0.
- **FSM states:** POR, ASSERT, HOLD, IDLE.
  - **POR:** entered after `rst_n` release. Runs RST_CYCLES counted cycles with `zrst_n` = 0, then goes to HOLD.
  - **IDLE:** `zrst_n` = 1, `rst_busy` = 0.
    - SPI event → ASSERT, `rst_src` <= 0.
    - Button event → ASSERT, `rst_src` <= 1.
    - Both in the same cycle: SPI wins (`rst_src` = 0).
  - **ASSERT:**
    - `zrst_n` = 0, `rst_busy` = 1; the counter runs 0..RST_CYCLES-1.
    - Further events during ASSERT are ignored and do not restart the counter.
    - On the last count cycle, `rom_sel` <= synchronised `rstrom` if `rst_src` = 0, else BTN_ROM. Then go to HOLD.
  - **HOLD:**
    - `zrst_n` = 0, `rst_busy` = 1.
    - Stay until synchronised `genrst` = 0 AND debounced button = released, then go to IDLE.
    - Prevents retriggering from a held request or button.
- **Outputs:**
  - `zrst_n` goes high on the first IDLE cycle.
  - Total low time ≥ RST_CYCLES+1 cycles.
  - `rom_sel` never changes while `zrst_n` = 1.
- **`rst_n` asserted mid-sequence:** immediate return to the reset values, then POR.
- **Counter width:** $clog2(RST_CYCLES). The counter clears on every state entry and never wraps within a state.

Decomposition:
- Shared package:
  - FSM state encoding (POR/ASSERT/HOLD/IDLE).
  - `rst_src` constants SRC_SPI = 0, SRC_BTN = 1.
  - Default ROM code constant.
- One sub-module: `btn_debounce` (synchroniser + counter + falling-event output), parameterised by DEB_BITS.
- Plain 2-flop synchronisers are instantiated inline.

Test Plan (RST_CYCLES = 8, DEB_BITS = 3 unless stated):
1. **Power-on:** release `rst_n`, with `genrst` = 0 and button released → `zrst_n` = 0 for 8 cycles plus HOLD, then `zrst_n` = 1; `rom_sel` = 00, `rst_busy` = 0.
2. **SPI reset:** in IDLE, `rstrom` = 2'b10, then raise `genrst` and hold 40 cycles → `zrst_n` low from edge+4 cycles; `rom_sel` = 10 set on the last ASSERT cycle; `zrst_n` stays low until 3 cycles after `genrst` falls; `rst_src` = 0.
3. **Button bounce:** toggle `btn_rst_n` every 3 cycles for 30 cycles → no reset. Then hold low 20 cycles → one reset, `rom_sel` = BTN_ROM = 00, `rst_src` = 1.
4. **Simultaneous events:** SPI event and button event in the same cycle, `rstrom` = 01 → `rst_src` = 0, `rom_sel` = 01, exactly one reset pulse.
5. **Retrigger ignored:** pulse `genrst` again during ASSERT → pulse length unchanged at 8 ASSERT cycles; no second sequence after IDLE while `genrst` = 0.
6. **Mid-sequence reset:** assert `rst_n` = 0 during ASSERT with `rom_sel` previously 11 → outputs return immediately to the reset values (`rom_sel` = 00, `zrst_n` = 0, `rst_busy` = 1, `rst_src` = 0); after release a full POR sequence runs.
